pipe_hazard_ctrl: RTL and testbench

//   Parametrised hazard/forwarding controller for the 5-stage miniRV pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage miniRV pipeline: EX>MEM>WB forwarding,
// load-use stall, branch flush and a wait-state FSM for multicycle DRAM. Perf counters under `HZ_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RAW     = 5,
  parameter int unsigned MEM_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            re1_id,
  input  logic            re2_id,
  input  logic [RAW-1:0]  rr1_id,
  input  logic [RAW-1:0]  rr2_id,
  input  logic            we_ex,
  input  logic            we_mem,
  input  logic            we_wb,
  input  logic [RAW-1:0]  wr_ex,
  input  logic [RAW-1:0]  wr_mem,
  input  logic [RAW-1:0]  wr_wb,
  input  logic [XLEN-1:0] wd_ex,
  input  logic [XLEN-1:0] wd_mem,
  input  logic [XLEN-1:0] wd_wb,
  input  logic            ld_ex,
  input  logic            mem_req,
  input  logic            npc_op_ex,
  output logic            stall_pc,
  output logic            stall_if_id,
  output logic            stall_id_ex,
  output logic            stall_ex_mem,
  output logic            stall_mem_wb,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_mem_wb,
  output logic [XLEN-1:0] rd1_f,
  output logic [XLEN-1:0] rd2_f,
  output logic            rd1_op,
  output logic            rd2_op,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
);

  // Wait counter must hold MEM_LAT; keep at least one bit so MEM_LAT=0 still elaborates.
  localparam int unsigned WCNT_W = (MEM_LAT == 0) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_LAT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mstall;
  logic              lu;

  logic m1_ex, m1_mem, m1_wb;
  logic m2_ex, m2_mem, m2_wb;

  // Per-stage RAW matches; x0 is never a forwarding source.
  always_comb begin
    m1_ex  = re1_id && we_ex  && (wr_ex  != '0) && (wr_ex  == rr1_id);
    m1_mem = re1_id && we_mem && (wr_mem != '0) && (wr_mem == rr1_id);
    m1_wb  = re1_id && we_wb  && (wr_wb  != '0) && (wr_wb  == rr1_id);
    m2_ex  = re2_id && we_ex  && (wr_ex  != '0) && (wr_ex  == rr2_id);
    m2_mem = re2_id && we_mem && (wr_mem != '0) && (wr_mem == rr2_id);
    m2_wb  = re2_id && we_wb  && (wr_wb  != '0) && (wr_wb  == rr2_id);
    lu     = ld_ex && (m1_ex || m2_ex);
  end

  // Forwarding mux: youngest producer wins.
  always_comb begin
    rd1_op = 1'b0;
    rd1_f  = '0;
    rd2_op = 1'b0;
    rd2_f  = '0;
    if (m1_ex) begin
      rd1_op = 1'b1;
      rd1_f  = wd_ex;
    end else if (m1_mem) begin
      rd1_op = 1'b1;
      rd1_f  = wd_mem;
    end else if (m1_wb) begin
      rd1_op = 1'b1;
      rd1_f  = wd_wb;
    end
    if (m2_ex) begin
      rd2_op = 1'b1;
      rd2_f  = wd_ex;
    end else if (m2_mem) begin
      rd2_op = 1'b1;
      rd2_f  = wd_mem;
    end else if (m2_wb) begin
      rd2_op = 1'b1;
      rd2_f  = wd_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state plus stall/flush resolution: mstall > branch > load-use.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_mem_wb = 1'b0;
    mstall       = mem_req && (wcnt_q != WCNT_MAX);

    case (state_q)
      S_IDLE: begin
        if (mem_req && (MEM_LAT != 0)) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_ONE;
        end
      end
      S_WAIT: begin
        if (!mem_req || (wcnt_q == WCNT_MAX)) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase

    if (!rst_n) begin
      state_d = S_IDLE;
      wcnt_d  = '0;
    end else if (mstall) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (npc_op_ex) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (lu) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  assign stall_mem_wb = 1'b0;

`ifdef HZ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // flush_if_id is only ever raised by a taken branch, so it doubles as the branch-flush event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_if_id && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: three instances (MEM_LAT 0/2/3) share one stimulus stream.
module tb_pipe_hazard_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
`ifdef HZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]      stall;
    logic [2:0]      flush;
    logic            op1;
    logic [XLEN-1:0] f1;
    logic            op2;
    logic [XLEN-1:0] f2;
  } obs_t;

  typedef struct {
    int    dut;
    string name;
    obs_t  v;
  } exp_t;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] v;
  } pexp_t;

  exp_t  sb[$];
  pexp_t psb[$];
  int    errors = 0;
  int    checks = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic re1_id, re2_id, we_ex, we_mem, we_wb, ld_ex, mem_req, npc_op_ex;
  logic [RAW-1:0]  rr1_id, rr2_id, wr_ex, wr_mem, wr_wb;
  logic [XLEN-1:0] wd_ex, wd_mem, wd_wb;

  logic stall_pc [3];
  logic stall_if_id [3];
  logic stall_id_ex [3];
  logic stall_ex_mem [3];
  logic stall_mem_wb [3];
  logic flush_if_id [3];
  logic flush_id_ex [3];
  logic flush_mem_wb [3];
  logic rd1_op [3];
  logic rd2_op [3];
  logic [XLEN-1:0] rd1_f [3];
  logic [XLEN-1:0] rd2_f [3];
  logic [31:0] pstall [3];
  logic [31:0] pflush [3];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .RAW(RAW), .MEM_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .re1_id(re1_id), .re2_id(re2_id), .rr1_id(rr1_id), .rr2_id(rr2_id),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .wr_ex(wr_ex), .wr_mem(wr_mem), .wr_wb(wr_wb),
    .wd_ex(wd_ex), .wd_mem(wd_mem), .wd_wb(wd_wb), .ld_ex(ld_ex), .mem_req(mem_req), .npc_op_ex(npc_op_ex),
    .stall_pc(stall_pc[0]), .stall_if_id(stall_if_id[0]), .stall_id_ex(stall_id_ex[0]),
    .stall_ex_mem(stall_ex_mem[0]), .stall_mem_wb(stall_mem_wb[0]), .flush_if_id(flush_if_id[0]),
    .flush_id_ex(flush_id_ex[0]), .flush_mem_wb(flush_mem_wb[0]), .rd1_f(rd1_f[0]), .rd2_f(rd2_f[0]),
    .rd1_op(rd1_op[0]), .rd2_op(rd2_op[0]), .perf_stall_cnt(pstall[0]), .perf_flush_cnt(pflush[0]));

  pipe_hazard_ctrl #(.XLEN(XLEN), .RAW(RAW), .MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .re1_id(re1_id), .re2_id(re2_id), .rr1_id(rr1_id), .rr2_id(rr2_id),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .wr_ex(wr_ex), .wr_mem(wr_mem), .wr_wb(wr_wb),
    .wd_ex(wd_ex), .wd_mem(wd_mem), .wd_wb(wd_wb), .ld_ex(ld_ex), .mem_req(mem_req), .npc_op_ex(npc_op_ex),
    .stall_pc(stall_pc[1]), .stall_if_id(stall_if_id[1]), .stall_id_ex(stall_id_ex[1]),
    .stall_ex_mem(stall_ex_mem[1]), .stall_mem_wb(stall_mem_wb[1]), .flush_if_id(flush_if_id[1]),
    .flush_id_ex(flush_id_ex[1]), .flush_mem_wb(flush_mem_wb[1]), .rd1_f(rd1_f[1]), .rd2_f(rd2_f[1]),
    .rd1_op(rd1_op[1]), .rd2_op(rd2_op[1]), .perf_stall_cnt(pstall[1]), .perf_flush_cnt(pflush[1]));

  pipe_hazard_ctrl #(.XLEN(XLEN), .RAW(RAW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .re1_id(re1_id), .re2_id(re2_id), .rr1_id(rr1_id), .rr2_id(rr2_id),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .wr_ex(wr_ex), .wr_mem(wr_mem), .wr_wb(wr_wb),
    .wd_ex(wd_ex), .wd_mem(wd_mem), .wd_wb(wd_wb), .ld_ex(ld_ex), .mem_req(mem_req), .npc_op_ex(npc_op_ex),
    .stall_pc(stall_pc[2]), .stall_if_id(stall_if_id[2]), .stall_id_ex(stall_id_ex[2]),
    .stall_ex_mem(stall_ex_mem[2]), .stall_mem_wb(stall_mem_wb[2]), .flush_if_id(flush_if_id[2]),
    .flush_id_ex(flush_id_ex[2]), .flush_mem_wb(flush_mem_wb[2]), .rd1_f(rd1_f[2]), .rd2_f(rd2_f[2]),
    .rd1_op(rd1_op[2]), .rd2_op(rd2_op[2]), .perf_stall_cnt(pstall[2]), .perf_flush_cnt(pflush[2]));

  localparam logic [4:0] S0 = 5'b00000, SM = 5'b11110, SL = 5'b11000;
  localparam logic [2:0] F0 = 3'b000, FM = 3'b001, FB = 3'b110, FL = 3'b010;

  function automatic obs_t snap(input int d);
    obs_t o;
    o.stall = {stall_pc[d], stall_if_id[d], stall_id_ex[d], stall_ex_mem[d], stall_mem_wb[d]};
    o.flush = {flush_if_id[d], flush_id_ex[d], flush_mem_wb[d]};
    o.op1   = rd1_op[d];
    o.f1    = rd1_f[d];
    o.op2   = rd2_op[d];
    o.f2    = rd2_f[d];
    return o;
  endfunction

  task automatic push(input int d, input string nm, input logic [4:0] st, input logic [2:0] fl,
                      input logic o1, input logic [XLEN-1:0] f1, input logic o2, input logic [XLEN-1:0] f2);
    exp_t e;
    e.dut = d;
    e.name = nm;
    e.v = '{stall: st, flush: fl, op1: o1, f1: f1, op2: o2, f2: f2};
    sb.push_back(e);
  endtask

  task automatic push_all(input string nm, input logic [4:0] st, input logic [2:0] fl,
                          input logic o1, input logic [XLEN-1:0] f1, input logic o2, input logic [XLEN-1:0] f2);
    for (int d = 0; d < 3; d++) push(d, nm, st, fl, o1, f1, o2, f2);
  endtask

  task automatic clear_inputs();
    re1_id = 1'b0; re2_id = 1'b0; rr1_id = '0; rr2_id = '0;
    we_ex = 1'b0; we_mem = 1'b0; we_wb = 1'b0;
    wr_ex = '0; wr_mem = '0; wr_wb = '0;
    wd_ex = '0; wd_mem = '0; wd_wb = '0;
    ld_ex = 1'b0; mem_req = 1'b0; npc_op_ex = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t got;
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          clear_inputs();
          ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd3; wd_ex = 32'h33;
          re1_id = 1'b1; rr1_id = 5'd3; npc_op_ex = 1'b1; mem_req = 1'b1;
          push_all("reset_hold", S0, F0, 1'b1, 32'h33, 1'b0, '0);
        end
        default: begin
          clear_inputs();
          rst_n = 1'b1;
          push_all("reset_release", S0, F0, 1'b0, '0, 1'b0, '0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s c%0d dut%0d: got %h expected %h", e.name, c, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_forward();
    exp_t e;
    obs_t got;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      we_ex = 1'b1; wr_ex = 5'd5; wd_ex = 32'h11;
      case (c)
        0: begin
          re1_id = 1'b1; rr1_id = 5'd5;
          push_all("fwd_ex_rs1", S0, F0, 1'b1, 32'h11, 1'b0, '0);
        end
        1: begin
          rr1_id = 5'd5;
          push_all("fwd_no_read", S0, F0, 1'b0, '0, 1'b0, '0);
        end
        2: begin
          re1_id = 1'b1; rr1_id = 5'd5; re2_id = 1'b1; rr2_id = 5'd5;
          push_all("fwd_ex_both", S0, F0, 1'b1, 32'h11, 1'b1, 32'h11);
        end
        default: begin
          wr_ex = 5'd0; re1_id = 1'b1; re2_id = 1'b1;
          push_all("fwd_x0", S0, F0, 1'b0, '0, 1'b0, '0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.name, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_priority();
    exp_t e;
    obs_t got;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      we_ex = 1'b1; we_mem = 1'b1; we_wb = 1'b1;
      wr_ex = 5'd7; wr_mem = 5'd7; wr_wb = 5'd7;
      wd_ex = 32'hA; wd_mem = 32'hB; wd_wb = 32'hC;
      re2_id = 1'b1; rr2_id = 5'd7;
      case (c)
        0: push_all("prio_ex", S0, F0, 1'b0, '0, 1'b1, 32'hA);
        1: begin
          we_ex = 1'b0;
          push_all("prio_mem", S0, F0, 1'b0, '0, 1'b1, 32'hB);
        end
        2: begin
          we_ex = 1'b0; we_mem = 1'b0;
          push_all("prio_wb", S0, F0, 1'b0, '0, 1'b1, 32'hC);
        end
        default: begin
          wr_ex = '0; wr_mem = '0; wr_wb = '0; rr2_id = '0;
          push_all("prio_x0", S0, F0, 1'b0, '0, 1'b0, '0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.name, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    obs_t got;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      case (c)
        0: begin
          ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd6; wd_ex = 32'hDEAD;
          re1_id = 1'b1; rr1_id = 5'd6;
          push_all("lu_rs1", SL, FL, 1'b1, 32'hDEAD, 1'b0, '0);
        end
        1: begin
          we_mem = 1'b1; wr_mem = 5'd6; wd_mem = 32'h66;
          re1_id = 1'b1; rr1_id = 5'd6;
          push_all("lu_after_mem", S0, F0, 1'b1, 32'h66, 1'b0, '0);
        end
        2: begin
          ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd9; wd_ex = 32'h99;
          re2_id = 1'b1; rr2_id = 5'd9;
          push_all("lu_rs2", SL, FL, 1'b0, '0, 1'b1, 32'h99);
        end
        default: begin
          ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd9; rr2_id = 5'd9;
          push_all("lu_no_read", S0, F0, 1'b0, '0, 1'b0, '0);
        end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.name, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_branch();
    exp_t e;
    obs_t got;
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      case (c)
        0: begin
          npc_op_ex = 1'b1;
          push_all("br_only", S0, FB, 1'b0, '0, 1'b0, '0);
        end
        1: begin
          npc_op_ex = 1'b1; ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd6; wd_ex = 32'h77;
          re1_id = 1'b1; rr1_id = 5'd6;
          push_all("br_over_lu", S0, FB, 1'b1, 32'h77, 1'b0, '0);
        end
        default: push_all("br_idle", S0, F0, 1'b0, '0, 1'b0, '0);
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.name, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    obs_t got;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      case (c)
        0, 1: begin
          mem_req = 1'b1; npc_op_ex = 1'b1;
          push(0, "mw_br_lat0", S0, FB, 1'b0, '0, 1'b0, '0);
          push(1, "mw_wait_lat2", SM, FM, 1'b0, '0, 1'b0, '0);
          push(2, "mw_wait_lat3", SM, FM, 1'b0, '0, 1'b0, '0);
        end
        2: begin
          mem_req = 1'b1; npc_op_ex = 1'b1;
          push(0, "mw_br_lat0", S0, FB, 1'b0, '0, 1'b0, '0);
          push(1, "mw_release_lat2", S0, FB, 1'b0, '0, 1'b0, '0);
          push(2, "mw_wait_lat3", SM, FM, 1'b0, '0, 1'b0, '0);
        end
        3: begin
          mem_req = 1'b1; npc_op_ex = 1'b1;
          push(0, "mw_br_lat0", S0, FB, 1'b0, '0, 1'b0, '0);
          push(1, "mw_b2b_lat2", SM, FM, 1'b0, '0, 1'b0, '0);
          push(2, "mw_release_lat3", S0, FB, 1'b0, '0, 1'b0, '0);
        end
        4: begin
          mem_req = 1'b1; ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd6; wd_ex = 32'h44;
          re1_id = 1'b1; rr1_id = 5'd6;
          push(0, "mw_lu_lat0", SL, FL, 1'b1, 32'h44, 1'b0, '0);
          push(1, "mw_lu_deferred2", SM, FM, 1'b1, 32'h44, 1'b0, '0);
          push(2, "mw_lu_deferred3", SM, FM, 1'b1, 32'h44, 1'b0, '0);
        end
        6: begin
          mem_req = 1'b1;
          push(0, "mw_req_lat0", S0, F0, 1'b0, '0, 1'b0, '0);
          push(1, "mw_after_drop2", SM, FM, 1'b0, '0, 1'b0, '0);
          push(2, "mw_after_drop3", SM, FM, 1'b0, '0, 1'b0, '0);
        end
        default: push_all("mw_idle", S0, F0, 1'b0, '0, 1'b0, '0);
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s c%0d dut%0d: got %h expected %h", e.name, c, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_wait();
    exp_t e;
    obs_t got;
    // Stall pattern per cycle for MEM_LAT=2 and MEM_LAT=3; cycle 2 has rst_n low.
    logic [7:0] st2 = 8'b0101_1011;
    logic [7:0] st3 = 8'b0011_1011;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      mem_req = (c < 7);
      rst_n = (c != 2);
      push(0, "rw_lat0", S0, F0, 1'b0, '0, 1'b0, '0);
      push(1, "rw_lat2", st2[c] ? SM : S0, st2[c] ? FM : F0, 1'b0, '0, 1'b0, '0);
      push(2, "rw_lat3", st3[c] ? SM : S0, st3[c] ? FM : F0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = snap(e.dut);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s c%0d dut%0d: got %h expected %h", e.name, c, e.dut, got, e.v);
        end
      end
      step();
    end
  endtask

  task automatic test_perf();
    pexp_t p;
    logic [31:0] got;
    for (int c = 0; c < 11; c++) begin
      clear_inputs();
      rst_n = (c != 0);
      if (c >= 2 && c <= 6) begin
        ld_ex = 1'b1; we_ex = 1'b1; wr_ex = 5'd6; re1_id = 1'b1; rr1_id = 5'd6;
      end
      if (c == 8 || c == 9) npc_op_ex = 1'b1;
      if (c == 0) begin
        psb.push_back('{sel: 0, name: "perf_stall_reset", v: 32'd0});
        psb.push_back('{sel: 1, name: "perf_flush_reset", v: 32'd0});
      end
      if (c == 7) psb.push_back('{sel: 0, name: "perf_stall_5", v: PERF ? 32'd5 : 32'd0});
      if (c == 10) begin
        psb.push_back('{sel: 0, name: "perf_stall_hold", v: PERF ? 32'd5 : 32'd0});
        psb.push_back('{sel: 1, name: "perf_flush_2", v: PERF ? 32'd2 : 32'd0});
      end
      @(negedge clk);
      while (psb.size() > 0) begin
        p = psb.pop_front();
        got = (p.sel == 0) ? pstall[0] : pflush[0];
        checks++;
        if (got !== p.v) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", p.name, got, p.v);
        end
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_forward();
    test_priority();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_wait();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
